// File: rtl/fpu_input_sequencer.sv
// Host-facing launcher for the FPU datapath core: captures operands and opcode,
// starts the core on a doorbell write and hands result/flags to the output register.
// Optional watchdog on the WAIT state is enabled by defining FPU_SEQ_TIMEOUT_EN.
module fpu_input_sequencer #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int NUM_OPS        = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [1:0]  wr_addr,
   input  logic [31:0] wr_data,
   output logic        core_start,
   output logic [31:0] core_op_a,
   output logic [31:0] core_op_b,
   output logic [2:0]  core_opcode,
   input  logic        core_done,
   input  logic [31:0] core_result,
   input  logic [3:0]  core_flags,
   output logic [31:0] result,
   output logic [3:0]  flags,
   output logic        fpu_doorbell_r_i,
   output logic        busy,
   output logic [1:0]  err
);

   localparam logic [31:0] QNAN       = 32'h7FC0_0000;
   localparam logic [3:0]  QNAN_FLAGS = 4'b1000;

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1024) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must lie in 2..1024");
   end

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;
   state_t state;

   logic op_valid;
   logic wd_expired;

   assign op_valid = int'(core_opcode) < NUM_OPS;

`ifdef FPU_SEQ_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CW-1:0] wd_cnt;

   assign wd_expired = (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

   // Counts completed WAIT cycles; zero in the first WAIT cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         wd_cnt <= '0;
      end else if (state == S_LAUNCH) begin
         wd_cnt <= '0;
      end else if (state == S_WAIT && !core_done) begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end
`else
   assign wd_expired = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= S_IDLE;
         core_start       <= 1'b0;
         core_op_a        <= '0;
         core_op_b        <= '0;
         core_opcode      <= '0;
         result           <= '0;
         flags            <= '0;
         fpu_doorbell_r_i <= 1'b0;
         busy             <= 1'b0;
         err              <= '0;
      end else begin
         core_start       <= 1'b0;
         fpu_doorbell_r_i <= 1'b0;
         if (wr_en && state != S_IDLE) begin
            err[0] <= 1'b1;
         end
         case (state)
            S_IDLE: begin
               if (wr_en) begin
                  case (wr_addr)
                     2'd0: core_op_a   <= wr_data;
                     2'd1: core_op_b   <= wr_data;
                     2'd2: core_opcode <= wr_data[2:0];
                     default: begin
                        // Opcode is stable here, so the start pulse can be registered now.
                        err        <= '0;
                        core_start <= op_valid;
                        busy       <= 1'b1;
                        state      <= S_LAUNCH;
                     end
                  endcase
               end
            end
            S_LAUNCH: begin
               if (op_valid) begin
                  state <= S_WAIT;
               end else begin
                  result           <= QNAN;
                  flags            <= QNAN_FLAGS;
                  err[1]           <= 1'b1;
                  fpu_doorbell_r_i <= 1'b1;
                  state            <= S_DONE;
               end
            end
            S_WAIT: begin
               if (core_done) begin
                  result           <= core_result;
                  flags            <= core_flags;
                  fpu_doorbell_r_i <= 1'b1;
                  state            <= S_DONE;
               end else if (wd_expired) begin
                  result           <= QNAN;
                  flags            <= QNAN_FLAGS;
                  err[1]           <= 1'b1;
                  fpu_doorbell_r_i <= 1'b1;
                  state            <= S_DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_input_sequencer.sv
// Directed bench for fpu_input_sequencer; watchdog scenarios run when
// FPU_SEQ_TIMEOUT_EN is defined, otherwise an unbounded wait is checked.
module tb_fpu_input_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [1:0]  wr_addr;
   logic [31:0] wr_data;
   logic        core_start;
   logic [31:0] core_op_a;
   logic [31:0] core_op_b;
   logic [2:0]  core_opcode;
   logic        core_done;
   logic [31:0] core_result;
   logic [3:0]  core_flags;
   logic [31:0] result;
   logic [3:0]  flags;
   logic        fpu_doorbell_r_i;
   logic        busy;
   logic [1:0]  err;

   int n_cmp = 0;
   int n_bad = 0;

   fpu_input_sequencer #(.TIMEOUT_CYCLES(4), .NUM_OPS(5)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .core_start(core_start), .core_op_a(core_op_a), .core_op_b(core_op_b),
      .core_opcode(core_opcode), .core_done(core_done), .core_result(core_result),
      .core_flags(core_flags), .result(result), .flags(flags),
      .fpu_doorbell_r_i(fpu_doorbell_r_i), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench in the cycle after the write (N+1).
   task automatic host_write(input logic [1:0] a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0; wr_addr = 2'd0; wr_data = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      core_done = 1'b0; core_result = '0; core_flags = '0;
      tick(); tick();
      reset = 1'b0;
      n_cmp++;
      if ({core_start, fpu_doorbell_r_i, busy, err, result, flags, core_op_a, core_op_b, core_opcode} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: start=%0b pulse=%0b busy=%0b err=%0b result=%h flags=%h a=%h b=%h op=%0d, required all 0",
                  core_start, fpu_doorbell_r_i, busy, err, result, flags, core_op_a, core_op_b, core_opcode);
      end
   endtask

   task automatic test_basic();
      host_write(2'd0, 32'h3F80_0000);
      host_write(2'd1, 32'h4000_0000);
      host_write(2'd2, 32'd0);
      host_write(2'd3, 32'd0);
      n_cmp++;
      if ({core_start, busy} !== 2'b11) begin
         n_bad++; $display("FAIL basic_n1: start,busy=%b required 11", {core_start, busy});
      end
      n_cmp++;
      if (core_op_a !== 32'h3F80_0000 || core_op_b !== 32'h4000_0000) begin
         n_bad++; $display("FAIL basic_operands: a=%h b=%h required 3f800000 40000000", core_op_a, core_op_b);
      end
      tick();
      n_cmp++;
      if ({core_start, fpu_doorbell_r_i, busy} !== 3'b001) begin
         n_bad++; $display("FAIL basic_n2: start,pulse,busy=%b required 001", {core_start, fpu_doorbell_r_i, busy});
      end
      tick();
      core_done = 1'b1; core_result = 32'h4040_0000; core_flags = 4'h0;
      tick();
      core_done = 1'b0;
      n_cmp++;
      if ({fpu_doorbell_r_i, busy, err} !== 4'b1100 || result !== 32'h4040_0000 || flags !== 4'h0) begin
         n_bad++; $display("FAIL basic_n4: pulse=%0b busy=%0b err=%b result=%h flags=%h required 1 1 00 40400000 0",
                           fpu_doorbell_r_i, busy, err, result, flags);
      end
      tick();
      n_cmp++;
      if ({fpu_doorbell_r_i, busy} !== 2'b00 || result !== 32'h4040_0000) begin
         n_bad++; $display("FAIL basic_n5: pulse=%0b busy=%0b result=%h required 0 0 40400000", fpu_doorbell_r_i, busy, result);
      end
   endtask

   task automatic test_min_latency();
      host_write(2'd3, 32'd0);
      tick();
      core_done = 1'b1; core_result = 32'h1234_5678; core_flags = 4'b0001;
      n_cmp++;
      if (busy !== 1'b1 || fpu_doorbell_r_i !== 1'b0) begin
         n_bad++; $display("FAIL minlat_n2: busy=%0b pulse=%0b required 1 0", busy, fpu_doorbell_r_i);
      end
      tick();
      core_done = 1'b0;
      n_cmp++;
      if ({fpu_doorbell_r_i, busy} !== 2'b11 || result !== 32'h1234_5678 || flags !== 4'b0001) begin
         n_bad++; $display("FAIL minlat_n3: pulse=%0b busy=%0b result=%h flags=%b required 1 1 12345678 0001",
                           fpu_doorbell_r_i, busy, result, flags);
      end
      tick();
      n_cmp++;
      if ({fpu_doorbell_r_i, busy} !== 2'b00) begin
         n_bad++; $display("FAIL minlat_n4: pulse,busy=%b required 00", {fpu_doorbell_r_i, busy});
      end
   endtask

   task automatic test_invalid_op();
      host_write(2'd2, 32'd7);
      host_write(2'd3, 32'd0);
      n_cmp++;
      if ({core_start, busy} !== 2'b01) begin
         n_bad++; $display("FAIL inv7_n1: start,busy=%b required 01", {core_start, busy});
      end
      tick();
      n_cmp++;
      if (fpu_doorbell_r_i !== 1'b1 || result !== 32'h7FC0_0000 || flags !== 4'b1000 || err !== 2'b10) begin
         n_bad++; $display("FAIL inv7_n2: pulse=%0b result=%h flags=%b err=%b required 1 7fc00000 1000 10",
                           fpu_doorbell_r_i, result, flags, err);
      end
      tick();
      n_cmp++;
      if ({fpu_doorbell_r_i, busy, err} !== 4'b0010) begin
         n_bad++; $display("FAIL inv7_n3: pulse=%0b busy=%0b err=%b required 0 0 10", fpu_doorbell_r_i, busy, err);
      end
      // NUM_OPS itself is the first illegal opcode
      host_write(2'd2, 32'd5);
      host_write(2'd3, 32'd0);
      n_cmp++;
      if (core_start !== 1'b0) begin
         n_bad++; $display("FAIL inv5_start: start=%0b required 0", core_start);
      end
      tick(); tick();
      // Largest legal opcode launches and clears the sticky error
      host_write(2'd2, 32'd4);
      host_write(2'd3, 32'd0);
      n_cmp++;
      if ({core_start, err} !== 3'b100 || core_opcode !== 3'd4) begin
         n_bad++; $display("FAIL op4_start: start=%0b err=%b op=%0d required 1 00 4", core_start, err, core_opcode);
      end
      tick();
      core_done = 1'b1; core_result = 32'h0000_00AA; core_flags = 4'b0010;
      tick();
      core_done = 1'b0;
      tick();
   endtask

   task automatic test_busy_drop();
      int pulses;
      host_write(2'd2, 32'd0);
      host_write(2'd0, 32'h1111_1111);
      host_write(2'd3, 32'd0);
      tick();
      host_write(2'd0, 32'hDEAD_BEEF);
      n_cmp++;
      if (core_op_a !== 32'h1111_1111 || err !== 2'b01) begin
         n_bad++; $display("FAIL drop_write: a=%h err=%b required 11111111 01", core_op_a, err);
      end
      host_write(2'd3, 32'd0);
      n_cmp++;
      if (err !== 2'b01 || busy !== 1'b1 || core_start !== 1'b0) begin
         n_bad++; $display("FAIL drop_doorbell: err=%b busy=%0b start=%0b required 01 1 0", err, busy, core_start);
      end
      core_done = 1'b1; core_result = 32'h5555_0000; core_flags = 4'h0;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         core_done = 1'b0;
         if (fpu_doorbell_r_i === 1'b1) pulses++;
      end
      n_cmp++;
      if (pulses !== 1 || busy !== 1'b0 || err !== 2'b01) begin
         n_bad++; $display("FAIL drop_single_pulse: pulses=%0d busy=%0b err=%b required 1 0 01", pulses, busy, err);
      end
      host_write(2'd3, 32'd0);
      n_cmp++;
      if (err !== 2'b00 || core_start !== 1'b1) begin
         n_bad++; $display("FAIL drop_clear: err=%b start=%0b required 00 1", err, core_start);
      end
      tick();
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      // Doorbell written while DONE is active is dropped
      host_write(2'd3, 32'd0);
      n_cmp++;
      if ({busy, err} !== 3'b001) begin
         n_bad++; $display("FAIL done_doorbell_drop: busy=%0b err=%b required 0 01", busy, err);
      end
      tick();
      n_cmp++;
      if ({busy, core_start} !== 2'b00) begin
         n_bad++; $display("FAIL done_no_relaunch: busy=%0b start=%0b required 0 0", busy, core_start);
      end
   endtask

   task automatic test_wait_limit();
      int pulses;
`ifdef FPU_SEQ_TIMEOUT_EN
      host_write(2'd3, 32'd0);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (fpu_doorbell_r_i === 1'b1) pulses++;
      end
      n_cmp++;
      if (pulses !== 0) begin
         n_bad++; $display("FAIL wd_early: pulses=%0d required 0", pulses);
      end
      tick();
      n_cmp++;
      if (fpu_doorbell_r_i !== 1'b1 || result !== 32'h7FC0_0000 || flags !== 4'b1000 || err[1] !== 1'b1) begin
         n_bad++; $display("FAIL wd_fire: pulse=%0b result=%h flags=%b err=%b required 1 7fc00000 1000 1x",
                           fpu_doorbell_r_i, result, flags, err);
      end
      tick();
      host_write(2'd3, 32'd0);
      tick(); tick(); tick();
      core_done = 1'b1; core_result = 32'hABCD_0123; core_flags = 4'b0100;
      tick();
      core_done = 1'b0;
      n_cmp++;
      if (fpu_doorbell_r_i !== 1'b1 || result !== 32'hABCD_0123 || flags !== 4'b0100 || err !== 2'b00) begin
         n_bad++; $display("FAIL wd_done_wins: pulse=%0b result=%h flags=%b err=%b required 1 abcd0123 0100 00",
                           fpu_doorbell_r_i, result, flags, err);
      end
      tick();
`else
      host_write(2'd3, 32'd0);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (fpu_doorbell_r_i === 1'b1) pulses++;
      end
      n_cmp++;
      if (pulses !== 0 || busy !== 1'b1) begin
         n_bad++; $display("FAIL long_wait: pulses=%0d busy=%0b required 0 1", pulses, busy);
      end
      core_done = 1'b1; core_result = 32'hABCD_0123; core_flags = 4'b0100;
      tick();
      core_done = 1'b0;
      n_cmp++;
      if (fpu_doorbell_r_i !== 1'b1 || result !== 32'hABCD_0123 || err !== 2'b00) begin
         n_bad++; $display("FAIL long_wait_done: pulse=%0b result=%h err=%b required 1 abcd0123 00",
                           fpu_doorbell_r_i, result, err);
      end
      tick();
`endif
   endtask

   task automatic test_reset_mid();
      int pulses;
      host_write(2'd0, 32'h0BAD_F00D);
      host_write(2'd3, 32'd0);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      core_done = 1'b1; core_result = 32'hFFFF_FFFF; core_flags = 4'hF;
      n_cmp++;
      if ({core_start, fpu_doorbell_r_i, busy, err, result, flags, core_op_a, core_op_b, core_opcode} !== '0) begin
         n_bad++; $display("FAIL reset_mid_outputs: start=%0b pulse=%0b busy=%0b err=%b result=%h flags=%h a=%h required all 0",
                           core_start, fpu_doorbell_r_i, busy, err, result, flags, core_op_a);
      end
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         core_done = 1'b0;
         if (fpu_doorbell_r_i === 1'b1 || busy === 1'b1) pulses++;
      end
      n_cmp++;
      if (pulses !== 0 || result !== 32'h0) begin
         n_bad++; $display("FAIL reset_mid_idle: activity=%0d result=%h required 0 0", pulses, result);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_min_latency();
      test_invalid_op();
      test_busy_drop();
      test_wait_limit();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
